// File: rtl/id_scoreboard.sv
// Decode-stage hazard controller: per-register pending-write counters drive a same-cycle stall/issue decision; counters update at clk.
// ex_ready low holds ID without counting a stall. Optional `SB_WB_BYPASS_EN lets a source retiring this cycle issue in the retire cycle.
module id_scoreboard #(
  parameter int NUM_REGS    = 32,
  parameter int IDX_W       = 5,
  parameter int CNT_W       = 2,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [IDX_W-1:0]       id_ra_idx,
  input  logic                   id_ra_used,
  input  logic [IDX_W-1:0]       id_rb_idx,
  input  logic                   id_rb_used,
  input  logic                   id_reg_wr,
  input  logic [IDX_W-1:0]       id_dest_idx,
  input  logic                   ex_ready,
  input  logic                   flash,
  input  logic                   wb_valid,
  input  logic [IDX_W-1:0]       wb_dest_idx,
  output logic                   issue,
  output logic                   stall_out,
  output logic [NUM_REGS-1:0]    busy_vec,
  output logic                   pending_any,
  output logic                   err_underflow,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  // Register 0 is never tracked, so the array starts at 1.
  logic [CNT_W-1:0] cnt [1:NUM_REGS-1];

  logic [CNT_W-1:0] ra_cnt, rb_cnt, rd_cnt, wb_cnt;
  logic             rd_hit, wb_hit;
  logic             ra_byp, rb_byp;
  logic             ra_haz, rb_haz, sat_haz;
  logic             inc, dec, underflow;

  // Lookups fall back to zero for index 0 and indices beyond NUM_REGS-1.
  always_comb begin
    ra_cnt   = '0;
    rb_cnt   = '0;
    rd_cnt   = '0;
    wb_cnt   = '0;
    rd_hit   = 1'b0;
    wb_hit   = 1'b0;
    busy_vec = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (id_ra_idx == IDX_W'(r)) ra_cnt = cnt[r];
      if (id_rb_idx == IDX_W'(r)) rb_cnt = cnt[r];
      if (id_dest_idx == IDX_W'(r)) begin
        rd_cnt = cnt[r];
        rd_hit = 1'b1;
      end
      if (wb_dest_idx == IDX_W'(r)) begin
        wb_cnt = cnt[r];
        wb_hit = 1'b1;
      end
      busy_vec[r] = (cnt[r] != '0);
    end
  end

`ifdef SB_WB_BYPASS_EN
  // The last outstanding write retiring now is forwarded by regfile write-through.
  assign ra_byp = wb_valid && (wb_dest_idx == id_ra_idx) && (ra_cnt == CNT_W'(1));
  assign rb_byp = wb_valid && (wb_dest_idx == id_rb_idx) && (rb_cnt == CNT_W'(1));
`else
  assign ra_byp = 1'b0;
  assign rb_byp = 1'b0;
`endif

  assign ra_haz  = id_ra_used && (ra_cnt != '0) && !ra_byp;
  assign rb_haz  = id_rb_used && (rb_cnt != '0) && !rb_byp;
  assign sat_haz = id_reg_wr && (rd_cnt == '1);

  assign stall_out   = id_valid && !flash && (ra_haz || rb_haz || sat_haz);
  assign issue       = id_valid && !flash && !stall_out && ex_ready;
  assign pending_any = |busy_vec;

  assign inc       = issue && id_reg_wr && rd_hit;
  assign dec       = wb_valid && wb_hit && (wb_cnt != '0);
  assign underflow = wb_valid && wb_hit && (wb_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < NUM_REGS; r++) cnt[r] <= '0;
      err_underflow <= 1'b0;
      stall_cycles  <= '0;
    end else begin
      // A same-index issue and retire cancel out.
      for (int r = 1; r < NUM_REGS; r++) begin
        if (inc && (id_dest_idx == IDX_W'(r)) && !(dec && (wb_dest_idx == IDX_W'(r))))
          cnt[r] <= cnt[r] + CNT_W'(1);
        else if (dec && (wb_dest_idx == IDX_W'(r)) && !(inc && (id_dest_idx == IDX_W'(r))))
          cnt[r] <= cnt[r] - CNT_W'(1);
      end
      if (underflow)
        err_underflow <= 1'b1;
      if (stall_out && (stall_cycles != '1))
        stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// Scoreboard bench for id_scoreboard: each scenario queues its expected outputs as it drives a step.
module tb_id_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_ra_used, id_rb_used, id_reg_wr;
  logic [4:0]  id_ra_idx, id_rb_idx, id_dest_idx, wb_dest_idx;
  logic        ex_ready, flash, wb_valid;
  logic        issue, stall_out, pending_any, err_underflow;
  logic [31:0] busy_vec;
  logic [31:0] stall_cycles;

  int vectors     = 0;
  int miscompares = 0;
  int exp_sc      = 0;

  id_scoreboard #(.NUM_REGS(32), .IDX_W(5), .CNT_W(2), .STALL_CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ra_idx(id_ra_idx), .id_ra_used(id_ra_used),
    .id_rb_idx(id_rb_idx), .id_rb_used(id_rb_used),
    .id_reg_wr(id_reg_wr), .id_dest_idx(id_dest_idx),
    .ex_ready(ex_ready), .flash(flash),
    .wb_valid(wb_valid), .wb_dest_idx(wb_dest_idx),
    .issue(issue), .stall_out(stall_out), .busy_vec(busy_vec),
    .pending_any(pending_any), .err_underflow(err_underflow),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Expected word layout: {issue, stall_out, err_underflow, pending_any, busy_vec}
  typedef struct {
    string       tag;
    logic        v, au;
    logic [4:0]  a;
    logic        bu;
    logic [4:0]  b;
    logic        wr;
    logic [4:0]  d;
    logic        rdy, fl, wbv;
    logic [4:0]  wbd;
    logic [35:0] exp;
  } step_t;

  step_t sb_q[$];
  step_t e;
  logic [35:0] got;

  function automatic logic [31:0] bm(input int n);
    return 32'h1 << n;
  endfunction

  function automatic step_t st(input string tag, input logic v, au, input logic [4:0] a,
                               input logic bu, input logic [4:0] b, input logic wr,
                               input logic [4:0] d, input logic rdy, fl, wbv,
                               input logic [4:0] wbd, input logic i, s, er,
                               input logic [31:0] busy);
    step_t t;
    t.tag = tag; t.v = v; t.au = au; t.a = a; t.bu = bu; t.b = b;
    t.wr = wr; t.d = d; t.rdy = rdy; t.fl = fl; t.wbv = wbv; t.wbd = wbd;
    t.exp = {i, s, er, |busy, busy};
    return t;
  endfunction

  function automatic logic [35:0] obs();
    return {issue, stall_out, err_underflow, pending_any, busy_vec};
  endfunction

  task automatic idle();
    id_valid = 0; id_ra_used = 0; id_ra_idx = 0; id_rb_used = 0; id_rb_idx = 0;
    id_reg_wr = 0; id_dest_idx = 0; ex_ready = 0; flash = 0; wb_valid = 0; wb_dest_idx = 0;
  endtask

  task automatic apply(input step_t t);
    id_valid = t.v; id_ra_used = t.au; id_ra_idx = t.a; id_rb_used = t.bu; id_rb_idx = t.b;
    id_reg_wr = t.wr; id_dest_idx = t.d; ex_ready = t.rdy; flash = t.fl;
    wb_valid = t.wbv; wb_dest_idx = t.wbd;
    sb_q.push_back(t);
    if (t.exp[34]) exp_sc++;
  endtask

  task automatic test_reset();
    step_t t[$];
    idle();
    rst = 1'b1;
    sb_q.push_back(st("reset_state", 0,0,0,0,0,0,0,0,0,0,0, 0,0,0, 32'h0));
    #2;
    got = obs(); e = sb_q.pop_front(); vectors++;
    if (got !== e.exp || stall_cycles !== 32'd0) begin
      miscompares++;
      $display("FAIL %s: got %h sc=%0d expected %h sc=0", e.tag, got, stall_cycles, e.exp);
    end
    @(negedge clk); rst = 1'b0; exp_sc = 0;
    t.push_back(st("rst_w5_a",   1,0,0,0,0,1,5,1,0,0,0, 1,0,0, 32'h0));
    t.push_back(st("rst_w5_b",   1,0,0,0,0,1,5,1,0,0,0, 1,0,0, bm(5)));
    t.push_back(st("rst_stall",  1,1,5,0,0,0,0,1,0,0,0, 0,1,0, bm(5)));
    t.push_back(st("rst_unf_x6", 1,1,5,0,0,0,0,1,0,1,6, 0,1,0, bm(5)));
    t.push_back(st("rst_idle",   0,0,0,0,0,0,0,0,0,0,0, 0,0,1, bm(5)));
    foreach (t[k]) begin
      @(negedge clk); apply(t[k]); #1;
      got = obs(); e = sb_q.pop_front(); vectors++;
      if (got !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.tag, got, e.exp);
      end
    end
    vectors++;
    if (stall_cycles !== 32'(exp_sc)) begin
      miscompares++;
      $display("FAIL rst_stall_cycles: got %0d expected %0d", stall_cycles, exp_sc);
    end
    // Asynchronous reset well away from any clock edge.
    @(negedge clk); #2; rst = 1'b1; exp_sc = 0;
    sb_q.push_back(st("midrun_reset", 0,0,0,0,0,0,0,0,0,0,0, 0,0,0, 32'h0));
    #1;
    got = obs(); e = sb_q.pop_front(); vectors++;
    if (got !== e.exp || stall_cycles !== 32'd0) begin
      miscompares++;
      $display("FAIL %s: got %h sc=%0d expected %h sc=0", e.tag, got, stall_cycles, e.exp);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_raw();
    step_t t[$];
    t.push_back(st("raw_issue_w3",  1,0,0,0,0,1,3,1,0,0,0, 1,0,0, 32'h0));
    t.push_back(st("raw_stall_ra3", 1,1,3,0,0,0,0,1,0,0,0, 0,1,0, bm(3)));
`ifdef SB_WB_BYPASS_EN
    t.push_back(st("raw_retire_cyc", 1,1,3,0,0,0,0,1,0,1,3, 1,0,0, bm(3)));
    t.push_back(st("raw_after",      0,0,0,0,0,0,0,0,0,0,0, 0,0,0, 32'h0));
`else
    t.push_back(st("raw_retire_cyc", 1,1,3,0,0,0,0,1,0,1,3, 0,1,0, bm(3)));
    t.push_back(st("raw_after",      1,1,3,0,0,0,0,1,0,0,0, 1,0,0, 32'h0));
`endif
    t.push_back(st("rb_issue_w8",  1,0,0,0,0,1,8,1,0,0,0, 1,0,0, 32'h0));
    t.push_back(st("rb_stall",     1,1,3,1,8,0,0,1,0,0,0, 0,1,0, bm(8)));
    t.push_back(st("rb_retire",    0,0,0,0,0,0,0,0,0,1,8, 0,0,0, bm(8)));
    t.push_back(st("rb_issue",     1,1,3,1,8,0,0,1,0,0,0, 1,0,0, 32'h0));
    t.push_back(st("raw_idle",     0,0,0,0,0,0,0,0,0,0,0, 0,0,0, 32'h0));
    foreach (t[k]) begin
      @(negedge clk); apply(t[k]); #1;
      got = obs(); e = sb_q.pop_front(); vectors++;
      if (got !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.tag, got, e.exp);
      end
    end
    vectors++;
    if (stall_cycles !== 32'(exp_sc)) begin
      miscompares++;
      $display("FAIL raw_stall_cycles: got %0d expected %0d", stall_cycles, exp_sc);
    end
  endtask

  task automatic test_saturation();
    step_t t[$];
    t.push_back(st("sat_w7_1",    1,0,0,0,0,1,7,1,0,0,0, 1,0,0, 32'h0));
    t.push_back(st("sat_w7_2",    1,0,0,0,0,1,7,1,0,0,0, 1,0,0, bm(7)));
    t.push_back(st("sat_w7_3",    1,0,0,0,0,1,7,1,0,0,0, 1,0,0, bm(7)));
    t.push_back(st("sat_stall_a", 1,0,0,0,0,1,7,1,0,0,0, 0,1,0, bm(7)));
    t.push_back(st("sat_stall_b", 1,0,0,0,0,1,7,1,0,0,0, 0,1,0, bm(7)));
    t.push_back(st("sat_retire",  1,0,0,0,0,1,7,1,0,1,7, 0,1,0, bm(7)));
    t.push_back(st("sat_issue",   1,0,0,0,0,1,7,1,0,0,0, 1,0,0, bm(7)));
    t.push_back(st("sat_drain_3", 0,0,0,0,0,0,0,0,0,1,7, 0,0,0, bm(7)));
    t.push_back(st("sat_drain_2", 0,0,0,0,0,0,0,0,0,1,7, 0,0,0, bm(7)));
    t.push_back(st("sat_drain_1", 0,0,0,0,0,0,0,0,0,1,7, 0,0,0, bm(7)));
    t.push_back(st("sat_empty",   0,0,0,0,0,0,0,0,0,0,0, 0,0,0, 32'h0));
    foreach (t[k]) begin
      @(negedge clk); apply(t[k]); #1;
      got = obs(); e = sb_q.pop_front(); vectors++;
      if (got !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.tag, got, e.exp);
      end
    end
    vectors++;
    if (stall_cycles !== 32'(exp_sc)) begin
      miscompares++;
      $display("FAIL sat_stall_cycles: got %0d expected %0d", stall_cycles, exp_sc);
    end
  endtask

  task automatic test_same_cycle();
    step_t t[$];
    t.push_back(st("same_w4",      1,0,0,0,0,1,4,1,0,0,0, 1,0,0, 32'h0));
    t.push_back(st("same_w4_wb4",  1,0,0,0,0,1,4,1,0,1,4, 1,0,0, bm(4)));
    t.push_back(st("same_hold",    0,0,0,0,0,0,0,0,0,0,0, 0,0,0, bm(4)));
    t.push_back(st("same_retire",  0,0,0,0,0,0,0,0,0,1,4, 0,0,0, bm(4)));
    t.push_back(st("same_empty",   0,0,0,0,0,0,0,0,0,0,0, 0,0,0, 32'h0));
    foreach (t[k]) begin
      @(negedge clk); apply(t[k]); #1;
      got = obs(); e = sb_q.pop_front(); vectors++;
      if (got !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.tag, got, e.exp);
      end
    end
  endtask

  task automatic test_flash_x0();
    step_t t[$];
    t.push_back(st("fl_w2",        1,0,0,0,0,1,2,1,0,0,0, 1,0,0, 32'h0));
    t.push_back(st("fl_squash",    1,1,2,0,0,1,5,1,1,0,0, 0,0,0, bm(2)));
    t.push_back(st("fl_no_w5",     0,0,0,0,0,0,0,0,0,0,0, 0,0,0, bm(2)));
    t.push_back(st("x0_write",     1,0,0,0,0,1,0,1,0,0,0, 1,0,0, bm(2)));
    t.push_back(st("x0_read",      1,1,0,1,0,1,0,1,0,0,0, 1,0,0, bm(2)));
    t.push_back(st("fl_retire2",   0,0,0,0,0,0,0,0,0,1,2, 0,0,0, bm(2)));
    t.push_back(st("fl_empty",     0,0,0,0,0,0,0,0,0,0,0, 0,0,0, 32'h0));
    foreach (t[k]) begin
      @(negedge clk); apply(t[k]); #1;
      got = obs(); e = sb_q.pop_front(); vectors++;
      if (got !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.tag, got, e.exp);
      end
    end
    vectors++;
    if (stall_cycles !== 32'(exp_sc)) begin
      miscompares++;
      $display("FAIL fl_stall_cycles: got %0d expected %0d", stall_cycles, exp_sc);
    end
  endtask

  task automatic test_back_to_back();
    step_t t[$];
    t.push_back(st("bp_hold_a",    1,0,0,0,0,1,6,0,0,0,0, 0,0,0, 32'h0));
    t.push_back(st("bp_hold_b",    1,0,0,0,0,1,6,0,0,0,0, 0,0,0, 32'h0));
    t.push_back(st("bp_release",   1,0,0,0,0,1,6,1,0,0,0, 1,0,0, 32'h0));
    t.push_back(st("bp_haz_nrdy",  1,1,6,0,0,0,0,0,0,0,0, 0,1,0, bm(6)));
    t.push_back(st("bp_retire6",   0,0,0,0,0,0,0,0,0,1,6, 0,0,0, bm(6)));
    t.push_back(st("bp_empty",     0,0,0,0,0,0,0,0,0,0,0, 0,0,0, 32'h0));
    foreach (t[k]) begin
      @(negedge clk); apply(t[k]); #1;
      got = obs(); e = sb_q.pop_front(); vectors++;
      if (got !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.tag, got, e.exp);
      end
    end
    vectors++;
    if (stall_cycles !== 32'(exp_sc)) begin
      miscompares++;
      $display("FAIL bp_stall_cycles: got %0d expected %0d", stall_cycles, exp_sc);
    end
  endtask

  task automatic test_underflow();
    step_t t[$];
    t.push_back(st("unf_wb9",      0,0,0,0,0,0,0,0,0,1,9, 0,0,0, 32'h0));
    t.push_back(st("unf_sticky",   0,0,0,0,0,0,0,0,0,0,0, 0,0,1, 32'h0));
    t.push_back(st("unf_w9",       1,0,0,0,0,1,9,1,0,0,0, 1,0,1, 32'h0));
    t.push_back(st("unf_retire9",  0,0,0,0,0,0,0,0,0,1,9, 0,0,1, bm(9)));
    t.push_back(st("unf_empty",    0,0,0,0,0,0,0,0,0,0,0, 0,0,1, 32'h0));
    foreach (t[k]) begin
      @(negedge clk); apply(t[k]); #1;
      got = obs(); e = sb_q.pop_front(); vectors++;
      if (got !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.tag, got, e.exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_saturation();
    test_same_cycle();
    test_flash_x0();
    test_back_to_back();
    test_underflow();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
